// File: rtl/uart_frame_sequencer_if.sv
// Signal bundle between the frame sequencer and the board start/abort logic, the UART block and the NN core.
// Latency: none; wires only.
// Backpressure: none; hold_clk and nn_done are the only completion signals.
interface uart_frame_sequencer_if;
    logic        frame_req;
    logic        abort;
    logic        hold_clk;
    logic        nn_done;
    logic        recv_int;
    logic        send_int;
    logic [31:0] target_addr;
    logic        nn_start;
    logic        ram_sel;
    logic        busy;
    logic        frame_done;
    logic        err;
    logic [15:0] frame_count;

    modport master (
        input  frame_req,
        input  abort,
        input  hold_clk,
        input  nn_done,
        output recv_int,
        output send_int,
        output target_addr,
        output nn_start,
        output ram_sel,
        output busy,
        output frame_done,
        output err,
        output frame_count
    );

    modport slave (
        output frame_req,
        output abort,
        output hold_clk,
        output nn_done,
        input  recv_int,
        input  send_int,
        input  target_addr,
        input  nn_start,
        input  ram_sel,
        input  busy,
        input  frame_done,
        input  err,
        input  frame_count
    );
endinterface

// File: rtl/uart_frame_sequencer.sv
// Sequences one inference frame: UART receive of the image, NN run, UART transmit of the result; owns ram_sel.
// Latency: every transition and output is one registered edge; watchdog built only with UART_FRAME_SEQ_WDOG_EN.
// Backpressure: waits on hold_clk / nn_done; frame_req outside IDLE is dropped, abort always wins.
module uart_frame_sequencer #(
    parameter logic [31:0] IMG_BASE       = 32'd0,
    parameter logic [31:0] RES_BASE       = 32'd3136,
    parameter logic [15:0] ARM_CYCLES     = 16'd8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd200_000_000
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    uart_frame_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RX_ARM,
        RX_RUN,
        NN_RUN,
        TX_ARM,
        TX_RUN,
        DONE,
        ERR
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        recv_r;
    logic        recv_nxt;
    logic        send_r;
    logic        send_nxt;
    logic        nn_start_r;
    logic        nn_start_nxt;
    logic        ram_sel_r;
    logic        ram_sel_nxt;
    logic        busy_r;
    logic        frame_done_r;
    logic        frame_done_nxt;
    logic        err_r;
    logic        err_nxt;
    logic [31:0] addr_r;
    logic [31:0] addr_nxt;
    logic [15:0] frame_cnt;
    logic [15:0] frame_cnt_nxt;
    logic        wdog_trip;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            recv_r       <= 1'b0;
            send_r       <= 1'b0;
            nn_start_r   <= 1'b0;
            ram_sel_r    <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            addr_r       <= 32'd0;
            frame_cnt    <= 16'd0;
        end else begin
            state        <= state_nxt;
            recv_r       <= recv_nxt;
            send_r       <= send_nxt;
            nn_start_r   <= nn_start_nxt;
            ram_sel_r    <= ram_sel_nxt;
            busy_r       <= (state_nxt != IDLE);
            frame_done_r <= frame_done_nxt;
            addr_r       <= addr_nxt;
            frame_cnt    <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        recv_nxt       = recv_r;
        send_nxt       = send_r;
        nn_start_nxt   = 1'b0;
        ram_sel_nxt    = ram_sel_r;
        frame_done_nxt = 1'b0;
        err_nxt        = err_r;
        addr_nxt       = addr_r;
        frame_cnt_nxt  = frame_cnt;

        case (state)
            IDLE: begin
                if (bus.frame_req) begin
                    state_nxt = RX_ARM;
                    recv_nxt  = 1'b1;
                    addr_nxt  = IMG_BASE;
                    err_nxt   = 1'b0;
                end
            end
            RX_ARM: begin
                if (bus.hold_clk) begin
                    state_nxt = RX_RUN;
                end
            end
            RX_RUN: begin
                // recv_int is held until the UART block drops hold_clk so it sees its own completion.
                if (!bus.hold_clk) begin
                    state_nxt    = NN_RUN;
                    recv_nxt     = 1'b0;
                    nn_start_nxt = 1'b1;
                    ram_sel_nxt  = 1'b1;
                end
            end
            NN_RUN: begin
                // RAM ownership swaps on the same edge: no gap between NN and UART access.
                if (bus.nn_done) begin
                    state_nxt   = TX_ARM;
                    ram_sel_nxt = 1'b0;
                    send_nxt    = 1'b1;
                    addr_nxt    = RES_BASE;
                end
            end
            TX_ARM: begin
                if (bus.hold_clk) begin
                    state_nxt = TX_RUN;
                end
            end
            TX_RUN: begin
                if (!bus.hold_clk) begin
                    state_nxt = DONE;
                    send_nxt  = 1'b0;
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                frame_done_nxt = 1'b1;
                frame_cnt_nxt  = frame_cnt + 16'd1;
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The watchdog only fires when the phase made no progress this cycle.
        if (wdog_trip && (state_nxt == state)) begin
            state_nxt    = ERR;
            recv_nxt     = 1'b0;
            send_nxt     = 1'b0;
            ram_sel_nxt  = 1'b0;
            nn_start_nxt = 1'b0;
            err_nxt      = 1'b1;
        end

        if (bus.abort) begin
            state_nxt      = IDLE;
            recv_nxt       = 1'b0;
            send_nxt       = 1'b0;
            ram_sel_nxt    = 1'b0;
            nn_start_nxt   = 1'b0;
            frame_done_nxt = 1'b0;
            err_nxt        = err_r;
            addr_nxt       = addr_r;
            frame_cnt_nxt  = frame_cnt;
        end
    end

`ifdef UART_FRAME_SEQ_WDOG_EN
    logic [31:0] phase_cnt;
    logic        arm_state;
    logic        run_state;

    assign arm_state = (state == RX_ARM) || (state == TX_ARM);
    assign run_state = (state == RX_RUN) || (state == NN_RUN) || (state == TX_RUN);
    assign wdog_trip = (arm_state && (phase_cnt == ({16'd0, ARM_CYCLES} - 32'd1))) ||
                       (run_state && (phase_cnt == (TIMEOUT_CYCLES - 32'd1)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            phase_cnt <= 32'd0;
        end else if ((state_nxt != state) || !(arm_state || run_state)) begin
            phase_cnt <= 32'd0;
        end else begin
            phase_cnt <= phase_cnt + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_nxt;
        end
    end
`else
    logic unused_wdog_cfg;

    assign wdog_trip       = 1'b0;
    assign err_r           = 1'b0;
    assign unused_wdog_cfg = ^{ARM_CYCLES, TIMEOUT_CYCLES, err_nxt};
`endif

    assign bus.recv_int    = recv_r;
    assign bus.send_int    = send_r;
    assign bus.target_addr = addr_r;
    assign bus.nn_start    = nn_start_r;
    assign bus.ram_sel     = ram_sel_r;
    assign bus.busy        = busy_r;
    assign bus.frame_done  = frame_done_r;
    assign bus.err         = err_r;
    assign bus.frame_count = frame_cnt;

endmodule

// File: doc/uart_frame_sequencer.md
# uart_frame_sequencer

Top-level controller that sequences one full inference frame through the UART transfer block and the neural-network core. It requests receive of a 784-word image into RAM, hands RAM ownership to the NN core, and requests transmit of the 10-word result. It also arbitrates the shared RAM port with `ram_sel`. It sits between the board-level start/abort logic, the UART transfer block (`recv_int`/`send_int`/`target_addr`/`hold_clk`) and the NN core (`nn_start`/`nn_done`).

## Interface
Parameters:
- `IMG_BASE`, 32'd0, RAM byte address of the first image word.
- `RES_BASE`, 32'd3136, RAM byte address of the first result word (784*4).
- `ARM_CYCLES`, 16'd8, maximum cycles from `recv_int`/`send_int` rise to `hold_clk` rise.
- `TIMEOUT_CYCLES`, 32'd200_000_000, watchdog limit per phase.

Ports:
- `sys_clk`, in, 1, clock.
- `sys_rst_n`, in, 1, asynchronous, active-low reset.
- `frame_req`, in, 1, single-cycle pulse that starts a frame.
- `abort`, in, 1, synchronous abort; returns to IDLE.
- `hold_clk`, in, 1, high while the UART block is transferring.
- `nn_done`, in, 1, single-cycle pulse when the NN core finishes.
- `recv_int`, out, 1, receive request level.
- `send_int`, out, 1, transmit request level.
- `target_addr`, out, 32, base address for the active transfer.
- `nn_start`, out, 1, single-cycle NN start pulse.
- `ram_sel`, out, 1, RAM owner: 0 = UART, 1 = NN core.
- `busy`, out, 1, high in every state except IDLE.
- `frame_done`, out, 1, single-cycle pulse after a successful frame.
- `err`, out, 1, sticky error flag, cleared by the next accepted `frame_req`.
- `frame_count`, out, 16, number of completed frames.

## Operation
- States: IDLE, RX_ARM, RX_RUN, NN_RUN, TX_ARM, TX_RUN, DONE, ERR.
- IDLE:
  - `frame_req`=1 → RX_ARM.
  - On the same edge: `recv_int`←1, `target_addr`←IMG_BASE, `err`←0.
- RX_ARM:
  - `hold_clk`=1 → RX_RUN.
- RX_RUN:
  - `hold_clk`=0 → NN_RUN.
  - On the same edge: `recv_int`←0, `nn_start`←1 for one cycle, `ram_sel`←1.
  - `recv_int` stays high until `hold_clk` falls, so the UART block sees its completion.
- NN_RUN:
  - `nn_done`=1 → TX_ARM.
  - On the same edge: `ram_sel`←0, `send_int`←1, `target_addr`←RES_BASE.
- TX_ARM:
  - `hold_clk`=1 → TX_RUN.
- TX_RUN:
  - `hold_clk`=0 → DONE.
  - On the same edge: `send_int`←0.
- DONE:
  - `frame_done`=1 for one cycle.
  - `frame_count`←`frame_count`+1, wrapping 16'hFFFF→0.
  - Next state: IDLE.
- ERR:
  - `err`=1.
  - `recv_int`, `send_int`, `ram_sel` all 0.
  - Next state: IDLE after one cycle.
- `recv_int` and `send_int` are never high together.
- `ram_sel`=1 only in NN_RUN.
- `frame_req` in any state other than IDLE is ignored; no queueing.
- `abort` has priority over every transition:
  - Next state is IDLE; all request outputs deassert.
  - `err` and `frame_count` are unchanged.
- `abort` and `frame_req` in the same IDLE cycle: `abort` wins and the frame does not start.
- `nn_done` outside NN_RUN is ignored.
- `target_addr` is held stable for the whole RX or TX phase. It retains its last value in IDLE and NN_RUN.

## Timing
- Reset values: state IDLE, `target_addr`=0, `frame_count`=0; all 1-bit outputs 0.
- All outputs are registered; every transition takes one edge.
- `frame_req` pulse at edge N → `recv_int`=1 after edge N.
- `hold_clk` fall sampled at edge M → `nn_start` and `ram_sel` high after edge M. `nn_start` drops after M+1.
- `nn_done` at edge K → `send_int`=1 and `ram_sel`=0 after edge K. There are no idle cycles between RAM owners.
- TX completion at edge T → `frame_done` after T+1.
- Minimum frame overhead: 4 controller cycles beyond the UART and NN latencies.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The UART block observes `recv_int`/`send_int` fall.

## Configuration
- `UART_FRAME_SEQ_WDOG_EN` defined:
  - In RX_ARM/TX_ARM, `hold_clk` not seen within ARM_CYCLES → ERR.
  - In RX_RUN/NN_RUN/TX_RUN, phase cycle counter reaches TIMEOUT_CYCLES → ERR.
  - The counter clears on every state change.
- Undefined:
  - No counters are built and ERR is unreachable.
  - ARM and RUN states wait indefinitely; `err` is tied to 0.

## Test plan
- Reset, `frame_req`, UART model raises `hold_clk` 2 cycles later and drops it after 784 words; NN replies after 100 cycles; TX completes → `target_addr` 0 then 3136, one `nn_start` pulse, `ram_sel` high only between them, `frame_done` pulse, `frame_count`=1.
- Second `frame_req` during RX_RUN → ignored; a single frame completes; `frame_count` increments by exactly 1.
- `abort` during NN_RUN → IDLE next cycle, `ram_sel`=0, no `send_int`, `frame_count` unchanged, `busy`=0.
- With `UART_FRAME_SEQ_WDOG_EN`, `hold_clk` held 0 after `recv_int` → ERR after 8 cycles, `err`=1; next `frame_req` clears `err`.
- Force `frame_count`=16'hFFFF, complete a frame → `frame_count`=0.
- Assert `sys_rst_n`=0 mid TX_RUN → `send_int`, `busy` and `target_addr` read 0 without waiting for a clock edge.
